// File: rtl/rv32i_core_mc.sv
// rv32i_core_mc -- multi-cycle RV32I core.
// Each instruction walks FETCH -> EXEC -> [MEM] -> WB. Instruction and data
// memories sit behind req/ack handshakes, so wait-state memories work unchanged.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   imem_req_o/addr_o   fetch request and byte address (PC); held until imem_ack_i
//   imem_ack_i/rdata_i  fetch completion and instruction word
//   dmem_req_o/we_o     data request, 1 = store
//   dmem_be_o/addr_o    byte enables for the word at addr[ADDR_WIDTH-1:2], byte address
//   dmem_wdata_o        store data, replicated across lanes
//   dmem_ack_i/rdata_i  data completion and full load word
//   retire_o            one-cycle pulse per retired instruction
//   trap_o              sticky halt on illegal opcode or misalignment
//   debug_o             last value written back to rd
//
// state   | meaning
// S_FETCH | request instruction at PC, latch it on ack
// S_EXEC  | decode, read registers, ALU, resolve branch/jump, check for traps
// S_MEM   | data access held until ack; load data formatted on ack
// S_WB    | write rd, advance PC, pulse retire
// S_TRAP  | halted until reset, PC frozen at the faulting instruction
module rv32i_core_mc #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [31:0]           imem_rdata_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [3:0]            dmem_be_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  retire_o,
  output logic                  trap_o,
  output logic [DATA_WIDTH-1:0] debug_o
);
  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  state_t                state_q, state_d;
  logic                  run_q;       // keeps the first request off until one edge after reset release
  logic                  taken_q;
  logic [ADDR_WIDTH-1:0] pc_q, target_q;
  logic [31:0]           instr_q;
  logic [31:0]           res_q, debug_q;
  logic [31:0]           rf_q [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign opcode  = instr_q[6:0];
  assign rd      = instr_q[11:7];
  assign f3      = instr_q[14:12];
  assign rs1     = instr_q[19:15];
  assign rs2     = instr_q[24:20];
  assign imm_i   = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s   = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b   = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u   = {instr_q[31:12], 12'b0};
  assign imm_j   = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  logic [31:0] alu_b, alu_y;

  always_comb begin
    alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
    alu_y = '0;
    case (f3)
      3'b000:  alu_y = (opcode == OP_REG && instr_q[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_y = rs1_val << alu_b[4:0];
      3'b010:  alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_y = {31'b0, rs1_val < alu_b};
      3'b100:  alu_y = rs1_val ^ alu_b;
      3'b101:  alu_y = instr_q[30] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
      3'b110:  alu_y = rs1_val | alu_b;
      default: alu_y = rs1_val & alu_b;
    endcase
  end

  logic [ADDR_WIDTH-1:0] pc_plus4, target;
  logic [31:0]           eff_addr, exec_res, ld_lane, ld_val, st_wdata;
  logic [3:0]            st_be;
  logic                  br_cond, br_ok, taken, legal, reg_write, is_load, is_store;
  logic                  misalign_mem, trap_cond;

  always_comb begin
    pc_plus4  = pc_q + ADDR_WIDTH'(4);
    eff_addr  = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    br_cond   = 1'b0;
    br_ok     = 1'b1;
    case (f3)
      3'b000:  br_cond = (rs1_val == rs2_val);
      3'b001:  br_cond = (rs1_val != rs2_val);
      3'b100:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_cond = (rs1_val <  rs2_val);
      3'b111:  br_cond = (rs1_val >= rs2_val);
      default: br_ok   = 1'b0;
    endcase
    taken     = 1'b0;
    target    = pc_q + imm_b[ADDR_WIDTH-1:0];
    exec_res  = alu_y;
    reg_write = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OP_LUI:    begin reg_write = 1'b1; exec_res = imm_u; end
      OP_AUIPC:  begin reg_write = 1'b1; exec_res = 32'(pc_q) + imm_u; end
      OP_JAL:    begin
        reg_write = 1'b1; taken = 1'b1;
        target    = pc_q + imm_j[ADDR_WIDTH-1:0];
        exec_res  = 32'(pc_plus4);
      end
      OP_JALR:   begin
        reg_write = 1'b1; taken = 1'b1;
        target    = {eff_addr[ADDR_WIDTH-1:1], 1'b0};
        exec_res  = 32'(pc_plus4);
      end
      OP_BRANCH: begin taken = br_cond; legal = br_ok; end
      OP_LOAD:   begin reg_write = 1'b1; legal = (f3 != 3'b011) && (f3[2:1] != 2'b11); end
      OP_STORE:  legal = !f3[2] && (f3 != 3'b011);
      OP_IMM, OP_REG: reg_write = 1'b1;
      default:   legal = 1'b0;
    endcase
    // f3[1] selects word, f3[0] half for both loads and stores
    misalign_mem = f3[1] ? (eff_addr[1:0] != 2'b00) : (f3[0] & eff_addr[0]);
    trap_cond    = !legal || (taken && target[1:0] != 2'b00) || ((is_load || is_store) && misalign_mem);

    ld_lane = dmem_rdata_i >> {eff_addr[1:0], 3'b000};
    case (f3)
      3'b000:  ld_val = {{24{ld_lane[7]}}, ld_lane[7:0]};
      3'b001:  ld_val = {{16{ld_lane[15]}}, ld_lane[15:0]};
      3'b100:  ld_val = {24'b0, ld_lane[7:0]};
      3'b101:  ld_val = {16'b0, ld_lane[15:0]};
      default: ld_val = dmem_rdata_i;
    endcase
    st_be    = 4'b1111;
    st_wdata = rs2_val;
    case (f3[1:0])
      2'b00:   begin st_be = 4'b0001 << eff_addr[1:0]; st_wdata = {4{rs2_val[7:0]}}; end
      2'b01:   begin st_be = eff_addr[1] ? 4'b1100 : 4'b0011; st_wdata = {2{rs2_val[15:0]}}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (run_q && imem_ack_i) state_d = S_EXEC;
      S_EXEC:  begin
        if (trap_cond)                 state_d = S_TRAP;
        else if (is_load || is_store)  state_d = S_MEM;
        else                           state_d = S_WB;
      end
      S_MEM:   if (dmem_ack_i) state_d = S_WB;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q    <= 1'b0;
      pc_q     <= RESET_VECTOR;
      instr_q  <= '0;
      res_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      debug_q  <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        S_FETCH: if (run_q && imem_ack_i) instr_q <= imem_rdata_i;
        S_EXEC:  begin
          res_q    <= exec_res;
          taken_q  <= taken;
          target_q <= target;
        end
        S_MEM:   if (dmem_ack_i && is_load) res_q <= ld_val;
        S_WB:    begin
          pc_q <= taken_q ? target_q : pc_plus4;
          if (reg_write) begin
            debug_q <= res_q;
            if (rd != 5'd0) rf_q[rd] <= res_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req_o   = (state_q == S_FETCH) && run_q;
  assign imem_addr_o  = imem_req_o ? pc_q : '0;
  assign dmem_req_o   = (state_q == S_MEM);
  assign dmem_we_o    = dmem_req_o && is_store;
  assign dmem_be_o    = dmem_req_o ? st_be : 4'b0000;
  assign dmem_addr_o  = dmem_req_o ? eff_addr[ADDR_WIDTH-1:0] : '0;
  assign dmem_wdata_o = dmem_we_o ? DATA_WIDTH'(st_wdata) : '0;
  assign retire_o     = (state_q == S_WB);
  assign trap_o       = (state_q == S_TRAP);
  assign debug_o      = DATA_WIDTH'(debug_q);

endmodule

// File: tb/tb_rv32i_core_mc.sv
// tb_rv32i_core_mc -- directed bench for rv32i_core_mc with req/ack memory models.
module tb_rv32i_core_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_o, imem_ack_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = '0;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i = 1'b0;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i = '0;
  logic        retire_o, trap_o;
  logic [31:0] debug_o;

  always #5 clk = ~clk;

  rv32i_core_mc #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .retire_o(retire_o), .trap_o(trap_o), .debug_o(debug_o)
  );

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:255];
  int imem_wait = 0, icnt = 0;
  int cyc = 0, n_retire = 0, n_dreq = 0;
  int n_checks = 0, n_pass = 0;

  always @(posedge clk) begin
    cyc++;
    if (retire_o)   n_retire++;
    if (dmem_req_o) n_dreq++;
  end

  always @(negedge clk) begin
    if (imem_req_o) begin
      if (icnt >= imem_wait) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = imem[imem_addr_o[7:2]];
        icnt         = 0;
      end else begin
        imem_ack_i = 1'b0;
        icnt++;
      end
    end else begin
      imem_ack_i = 1'b0;
      icnt       = 0;
    end
  end

  always @(negedge clk) begin
    if (dmem_req_o) begin
      dmem_ack_i = 1'b1;
      if (dmem_we_o)
        for (int b = 0; b < 4; b++)
          if (dmem_be_o[b]) dmem[dmem_addr_o[9:2]][8*b +: 8] = dmem_wdata_o[8*b +: 8];
      dmem_rdata_i = dmem[dmem_addr_o[9:2]];
    end else begin
      dmem_ack_i = 1'b0;
    end
  end

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm[31:12], rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic wait_retire(input string tag, output int c);
    int k;
    c = -1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (retire_o) break;
    end
    if (k == 40) check({tag, "_timeout"}, retire_o, 1);
    else c = cyc;
  endtask

  task automatic retire_and_check(input string tag, input logic [31:0] exp);
    int c;
    wait_retire(tag, c);
    @(negedge clk);
    check(tag, debug_o, exp);
  endtask

  task automatic wait_dmem(input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dmem_req_o) break;
    end
    check({tag, "_dreq"}, dmem_req_o, 1);
  endtask

  task automatic wait_trap(input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (trap_o) break;
    end
    check(tag, trap_o, 1);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic restart();
    repeat (2) @(negedge clk);
    release_rst();
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, req_cycles, bad, got_ret, busy, r0, d0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    clear_imem();

    // program A: reset state, loads/stores, taken backward branch
    imem[0] = enc_i(5,      0, 3'b000, 1, 7'b0010011);
    imem[1] = enc_i(32'hAB, 0, 3'b000, 2, 7'b0010011);
    imem[2] = enc_i(32'h103,0, 3'b000, 3, 7'b0010011);
    imem[3] = enc_s(0, 2, 3, 3'b000);
    imem[4] = enc_u(32'h8000_0000, 4, 7'b0110111);
    imem[5] = enc_s(-3, 4, 3, 3'b010);
    imem[6] = enc_i(0, 3, 3'b000, 5, 7'b0000011);
    imem[7] = enc_i(0, 3, 3'b100, 6, 7'b0000011);
    imem[8] = enc_b(-8, 0, 0, 3'b000);

    repeat (3) @(negedge clk);
    check("rst_imem_req", imem_req_o, 0);
    check("rst_dmem_req", dmem_req_o, 0);
    check("rst_retire",   retire_o, 0);
    check("rst_trap",     trap_o, 0);
    check("rst_debug",    debug_o, 0);

    release_rst();
    check("first_req",  imem_req_o, 1);
    check("first_addr", imem_addr_o, 32'h0);
    t0 = cyc;
    wait_retire("addi_x1", t1);
    check("addi_latency", t1 - t0 + 1, 3);
    @(negedge clk);
    check("addi_x1", debug_o, 32'd5);
    retire_and_check("addi_x2", 32'hAB);
    retire_and_check("addi_x3", 32'h103);
    wait_dmem("sb");
    check("sb_we",    dmem_we_o, 1);
    check("sb_be",    dmem_be_o, 4'b1000);
    check("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
    check("sb_addr",  dmem_addr_o, 32'h103);
    wait_retire("sb", t1);
    retire_and_check("lui", 32'h8000_0000);
    wait_dmem("sw");
    check("sw_be", dmem_be_o, 4'b1111);
    wait_retire("sw", t1);
    check("sw_mem", dmem[64], 32'h8000_0000);
    retire_and_check("lb",  32'hFFFF_FF80);
    retire_and_check("lbu", 32'h0000_0080);
    wait_retire("beq", t1);
    @(negedge clk);
    check("beq_target", imem_addr_o, 32'h18);

    // program B: delayed fetch ack, ALU ops, JAL, misaligned JALR trap
    rst = 1'b0;
    clear_imem();
    imem[0] = enc_i(-7, 0, 3'b000, 1, 7'b0010011);
    imem[1] = enc_i(3,  0, 3'b000, 2, 7'b0010011);
    imem[2] = enc_r(7'b0100000, 2, 1, 3'b000, 3);
    imem[3] = enc_i(32'h401, 1, 3'b101, 4, 7'b0010011);
    imem[4] = enc_r(7'b0000000, 1, 2, 3'b011, 5);
    imem[5] = enc_r(7'b0000000, 1, 2, 3'b010, 6);
    imem[6] = enc_j(8, 7);
    imem[7] = enc_i(1, 0, 3'b000, 8, 7'b0010011);
    imem[8] = enc_i(32'h102, 0, 3'b000, 0, 7'b1100111);
    imem_wait = 4;
    r0 = n_retire;
    restart();
    t0 = cyc;
    t1 = -1;
    req_cycles = imem_req_o ? 1 : 0;
    bad = (imem_addr_o != 32'h0) ? 1 : 0;
    got_ret = 0;
    for (int k = 0; k < 20 && got_ret == 0; k++) begin
      @(negedge clk);
      if (retire_o) begin
        got_ret = 1;
        t1 = cyc;
      end else if (imem_req_o) begin
        req_cycles++;
        if (imem_addr_o != 32'h0) bad++;
      end
    end
    imem_wait = 0;
    check("wait_retired",     got_ret, 1);
    check("wait_latency",     t1 - t0 + 1, 7);
    check("wait_req_cycles",  req_cycles, 5);
    check("wait_addr_stable", bad, 0);
    @(negedge clk);
    check("wait_retire_once", n_retire - r0, 1);
    check("addi_neg",         debug_o, 32'hFFFF_FFF9);
    retire_and_check("addi_3", 32'd3);
    retire_and_check("sub",    32'hFFFF_FFF6);
    retire_and_check("srai",   32'hFFFF_FFFC);
    retire_and_check("sltu",   32'd1);
    retire_and_check("slt",    32'd0);
    retire_and_check("jal_link", 32'h1C);
    check("jal_target", imem_addr_o, 32'h20);
    wait_trap("jalr_trap");
    busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req_o || dmem_req_o || retire_o) busy++;
    end
    check("trap_quiet",  busy, 0);
    check("trap_sticky", trap_o, 1);
    check("trap_no_wb",  debug_o, 32'h1C);

    // program C: reset out of trap, mid-fetch reset, misaligned LW
    rst = 1'b0;
    #1;
    check("rst_clears_trap",  trap_o, 0);
    check("rst_clears_debug", debug_o, 0);
    clear_imem();
    imem[0] = enc_i(7, 0, 3'b000, 1, 7'b0010011);
    imem[1] = enc_i(2, 0, 3'b010, 2, 7'b0000011);
    imem_wait = 10;
    restart();
    check("restart_addr", imem_addr_o, 32'h0);
    check("restart_req",  imem_req_o, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midfetch_req_drop", imem_req_o, 0);
    imem_wait = 0;
    release_rst();
    check("refetch_req",  imem_req_o, 1);
    check("refetch_addr", imem_addr_o, 32'h0);
    retire_and_check("addi_7", 32'd7);
    d0 = n_dreq;
    wait_trap("lw_misalign_trap");
    check("lw_no_dreq", n_dreq - d0, 0);
    check("lw_no_wb",   debug_o, 32'd7);

    // program D: illegal opcode at the reset vector
    rst = 1'b0;
    clear_imem();
    imem[0] = 32'h0000_0000;
    restart();
    r0 = n_retire;
    wait_trap("illegal_trap");
    check("illegal_no_retire", n_retire - r0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
